// File: rtl/enc_pkg.sv
// ---------------------------------------------------------------------------
// enc_pkg
// Shared types and helpers for the pipelined priority encoder.
//   enc_mode_t : runtime encoding mode carried alongside each input beat
//   enc_w()    : code width for an N-bit request vector
// ---------------------------------------------------------------------------
package enc_pkg;

  // Encoding modes. The reserved code behaves like strict one-hot so that
  // an unexpected mode value never silently hides a multi-bit request.
  typedef enum logic [1:0] {
    ENC_MSB    = 2'd0,
    ENC_LSB    = 2'd1,
    ENC_STRICT = 2'd2,
    ENC_RSVD   = 2'd3
  } enc_mode_t;

  // Width of the encoded index for an n-bit request vector.
  function automatic int enc_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/prio_encoder_pipe_if.sv
// ---------------------------------------------------------------------------
// prio_encoder_pipe_if
// Valid/ready bus for the pipelined priority encoder.
//   in_valid / in_ready : input beat handshake
//   in_d, in_mode       : request vector and encoding mode of the beat
//   out_valid/out_ready : output beat handshake
//   out_code            : encoded index
//   out_any             : request vector was non-zero
//   out_err             : strict-mode one-hot violation
// Modports: master = beat source / result sink, slave = encoder.
// ---------------------------------------------------------------------------
interface prio_encoder_pipe_if
  import enc_pkg::*;
#(
  parameter int N = 8
);

  localparam int W = enc_w(N);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_d;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_code;
  logic          out_any;
  logic          out_err;

  modport master (
    output in_valid,
    output in_d,
    output in_mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_code,
    input  out_any,
    input  out_err
  );

  modport slave (
    input  in_valid,
    input  in_d,
    input  in_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_code,
    output out_any,
    output out_err
  );

endinterface

// File: rtl/enc_core.sv
// ---------------------------------------------------------------------------
// enc_core
// Purely combinational N-to-log2(N) encoder with selectable mode.
//   d    in  N : request vector
//   mode in  2 : encoding mode (enc_mode_t encoding)
//   code out W : encoded index (0 when d is zero or strict check fails)
//   any  out 1 : d is non-zero
//   err  out 1 : strict/reserved mode and d is not exactly one-hot
// ---------------------------------------------------------------------------
module enc_core
  import enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = enc_w(N)
) (
  input  logic [N-1:0] d,
  input  logic [1:0]   mode,
  output logic [W-1:0] code,
  output logic         any,
  output logic         err
);

  logic [W-1:0] msb_idx;
  logic [W-1:0] lsb_idx;
  logic         one_hot;

  // Highest set bit: scanning upward lets the last hit win.
  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (d[i]) msb_idx = W'(i);
    end
  end

  // Lowest set bit: scanning downward lets the last hit win.
  always_comb begin
    lsb_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (d[i]) lsb_idx = W'(i);
    end
  end

  // Clearing the lowest set bit leaves zero only for a single-bit vector,
  // so no popcount is needed.
  assign one_hot = (d != '0) && ((d & (d - N'(1))) == '0);
  assign any     = (d != '0);

  // In strict mode a one-hot vector's lowest set bit is its only set bit.
  always_comb begin
    code = '0;
    err  = 1'b0;
    case (enc_mode_t'(mode))
      ENC_MSB: code = msb_idx;
      ENC_LSB: code = lsb_idx;
      default: begin
        code = one_hot ? lsb_idx : '0;
        err  = !one_hot;
      end
    endcase
  end

endmodule

// File: rtl/prio_encoder_pipe.sv
// ---------------------------------------------------------------------------
// prio_encoder_pipe
// Registered priority encoder behind a valid/ready handshake, with a
// saturating count of accepted beats flagged as strict-mode errors.
//   clk       in  1     : clock, rising edge
//   rst       in  1     : synchronous active-high reset
//   bus       slave     : input/output beat handshake and payload
//   err_clr   in  1     : synchronous clear of err_count (wins over increment)
//   err_count out CNT_W : accepted error beats, saturating
// ---------------------------------------------------------------------------
module prio_encoder_pipe
  import enc_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int CNT_W = 8,
  localparam int W     = enc_w(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  prio_encoder_pipe_if.slave   bus,
  input  logic                 err_clr,
  output logic [CNT_W-1:0]     err_count
);

  logic [W-1:0]     core_code;
  logic             core_any;
  logic             core_err;
  logic             accept;
  logic             out_valid_q;
  logic [W-1:0]     code_q;
  logic             any_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  enc_core #(.N(N)) u_core (
    .d    (bus.in_d),
    .mode (bus.in_mode),
    .code (core_code),
    .any  (core_any),
    .err  (core_err)
  );

  // The output register may take a new beat when it is empty or being
  // drained this cycle, which gives one beat per cycle with no bubble.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Output valid flag: set by an accept, cleared by a transfer that has
  // no replacement beat arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Payload register only loads on accept, so it holds steady while the
  // downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q <= '0;
      any_q  <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      code_q <= core_code;
      any_q  <= core_any;
      err_q  <= core_err;
    end
  end

  // Error counter counts accepted error beats and sticks at all-ones;
  // a clear in the same cycle as an error accept leaves it at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (err_clr) begin
      cnt_q <= '0;
    end else if (accept && core_err && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = code_q;
  assign bus.out_any   = any_q;
  assign bus.out_err   = err_q;
  assign err_count     = cnt_q;

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// ---------------------------------------------------------------------------
// tb_prio_encoder_pipe
// Scoreboard bench for prio_encoder_pipe. Drivers push the expected result
// of each accepted beat into a per-instance queue; monitors on the falling
// edge compare every visible output beat against the queue head.
// Instances: N=8 (directed), N=8/CNT_W=2 (counter), N=16 and N=2 (sweeps).
// ---------------------------------------------------------------------------
module tb_prio_encoder_pipe;

  typedef struct {
    int code;
    bit any;
    bit err;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int nChecks = 0;
  int nFails  = 0;

  exp_t q8[$];
  exp_t q16[$];
  exp_t q2[$];
  int   expCnt8  = 0;
  int   expCnt16 = 0;
  int   expCnt2  = 0;

  logic       clr8  = 1'b0;
  logic       clrc  = 1'b0;
  logic       clr16 = 1'b0;
  logic       clr2  = 1'b0;
  logic [7:0] cnt8;
  logic [1:0] cntc;
  logic [7:0] cnt16;
  logic [7:0] cnt2;

  prio_encoder_pipe_if #(.N(8))  bus8  ();
  prio_encoder_pipe_if #(.N(8))  busc  ();
  prio_encoder_pipe_if #(.N(16)) bus16 ();
  prio_encoder_pipe_if #(.N(2))  bus2  ();

  prio_encoder_pipe #(.N(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8), .err_clr(clr8), .err_count(cnt8)
  );
  prio_encoder_pipe #(.N(8), .CNT_W(2)) dutc (
    .clk(clk), .rst(rst), .bus(busc), .err_clr(clrc), .err_count(cntc)
  );
  prio_encoder_pipe #(.N(16), .CNT_W(8)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16), .err_clr(clr16), .err_count(cnt16)
  );
  prio_encoder_pipe #(.N(2), .CNT_W(8)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .err_clr(clr2), .err_count(cnt2)
  );

  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Independent reference: bit scan with an explicit population count.
  function automatic exp_t refModel(input int n, input logic [15:0] d, input logic [1:0] m);
    exp_t e;
    int   pop;
    int   hi;
    int   lo;
    pop = 0;
    hi  = 0;
    lo  = 0;
    for (int i = 0; i < n; i++) begin
      if (d[i]) begin
        if (pop == 0) lo = i;
        hi = i;
        pop++;
      end
    end
    e.any = (pop != 0);
    e.cnt = 0;
    case (m)
      2'd0:    begin e.code = hi; e.err = 1'b0; end
      2'd1:    begin e.code = lo; e.err = 1'b0; end
      default: begin e.code = (pop == 1) ? lo : 0; e.err = (pop != 1); end
    endcase
    return e;
  endfunction

  // Issue one beat on the N=8 instance and hold it until accepted; the
  // expected result is queued at the cycle it is taken.
  task automatic applyStimulus(input logic [7:0] d, input logic [1:0] m,
                               input int code, input bit any, input bit err);
    bit done;
    exp_t e;
    done = 1'b0;
    bus8.in_valid = 1'b1;
    bus8.in_d     = d;
    bus8.in_mode  = m;
    for (int b = 0; b < 50 && !done; b++) begin
      @(negedge clk);
      if (bus8.in_ready) begin
        if (err && expCnt8 != 255) expCnt8++;
        e.code = code;
        e.any  = any;
        e.err  = err;
        e.cnt  = expCnt8;
        q8.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("dut8_accept", int'(done), 1);
    bus8.in_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Random stream on the N=16 instance, holding each beat until taken.
  task automatic sweep16(input int iters);
    bit pend;
    exp_t e;
    pend = 1'b0;
    for (int i = 0; i < iters; i++) begin
      if (!pend) begin
        bus16.in_valid = ($urandom_range(0, 3) != 0);
        bus16.in_d     = 16'($urandom);
        if ($urandom_range(0, 2) == 0) bus16.in_d = 16'h1 << $urandom_range(0, 15);
        bus16.in_mode  = 2'($urandom_range(0, 3));
      end
      bus16.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus16.in_valid && bus16.in_ready) begin
        e = refModel(16, bus16.in_d, bus16.in_mode);
        if (e.err && expCnt16 != 255) expCnt16++;
        e.cnt = expCnt16;
        q16.push_back(e);
        pend = 1'b0;
      end else begin
        pend = bus16.in_valid;
      end
      @(posedge clk);
      #1;
    end
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b1;
  endtask

  // Random stream on the N=2 instance.
  task automatic sweep2(input int iters);
    bit pend;
    exp_t e;
    pend = 1'b0;
    for (int i = 0; i < iters; i++) begin
      if (!pend) begin
        bus2.in_valid = ($urandom_range(0, 3) != 0);
        bus2.in_d     = 2'($urandom);
        bus2.in_mode  = 2'($urandom_range(0, 3));
      end
      bus2.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus2.in_valid && bus2.in_ready) begin
        e = refModel(2, {14'd0, bus2.in_d}, bus2.in_mode);
        if (e.err && expCnt2 != 255) expCnt2++;
        e.cnt = expCnt2;
        q2.push_back(e);
        pend = 1'b0;
      end else begin
        pend = bus2.in_valid;
      end
      @(posedge clk);
      #1;
    end
    bus2.in_valid  = 1'b0;
    bus2.out_ready = 1'b1;
  endtask

  // Monitor for the N=8 instance: every visible beat must match the queue
  // head, every cycle, so a stalled payload that drifts is caught too.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("dut8_in_ready", int'(bus8.in_ready), int'(!bus8.out_valid || bus8.out_ready));
      if (bus8.out_valid) begin
        checkOutput("dut8_beat_expected", int'(q8.size() > 0), 1);
        if (q8.size() > 0) begin
          checkOutput("dut8_code", int'(bus8.out_code), q8[0].code);
          checkOutput("dut8_any", int'(bus8.out_any), int'(q8[0].any));
          checkOutput("dut8_err", int'(bus8.out_err), int'(q8[0].err));
          checkOutput("dut8_err_count", int'(cnt8), q8[0].cnt);
          if (bus8.out_ready) void'(q8.pop_front());
        end
      end
    end
  end

  // Monitor for the N=16 instance.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("dut16_in_ready", int'(bus16.in_ready), int'(!bus16.out_valid || bus16.out_ready));
      if (bus16.out_valid) begin
        checkOutput("dut16_beat_expected", int'(q16.size() > 0), 1);
        if (q16.size() > 0) begin
          checkOutput("dut16_code", int'(bus16.out_code), q16[0].code);
          checkOutput("dut16_any", int'(bus16.out_any), int'(q16[0].any));
          checkOutput("dut16_err", int'(bus16.out_err), int'(q16[0].err));
          checkOutput("dut16_err_count", int'(cnt16), q16[0].cnt);
          if (bus16.out_ready) void'(q16.pop_front());
        end
      end
    end
  end

  // Monitor for the N=2 instance.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("dut2_in_ready", int'(bus2.in_ready), int'(!bus2.out_valid || bus2.out_ready));
      if (bus2.out_valid) begin
        checkOutput("dut2_beat_expected", int'(q2.size() > 0), 1);
        if (q2.size() > 0) begin
          checkOutput("dut2_code", int'(bus2.out_code), q2[0].code);
          checkOutput("dut2_any", int'(bus2.out_any), int'(q2[0].any));
          checkOutput("dut2_err", int'(bus2.out_err), int'(q2[0].err));
          checkOutput("dut2_err_count", int'(cnt2), q2[0].cnt);
          if (bus2.out_ready) void'(q2.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int satSeq[5];
    exp_t e;
    satSeq = '{1, 2, 3, 3, 3};

    bus8.in_valid  = 1'b0; bus8.in_d  = '0; bus8.in_mode  = 2'd0; bus8.out_ready  = 1'b1;
    busc.in_valid  = 1'b0; busc.in_d  = '0; busc.in_mode  = 2'd0; busc.out_ready  = 1'b1;
    bus16.in_valid = 1'b0; bus16.in_d = '0; bus16.in_mode = 2'd0; bus16.out_ready = 1'b1;
    bus2.in_valid  = 1'b0; bus2.in_d  = '0; bus2.in_mode  = 2'd0; bus2.out_ready  = 1'b1;

    // Reset held with a valid beat pending: nothing may come out.
    rst = 1'b1;
    bus8.in_valid = 1'b1;
    bus8.in_d     = 8'h2C;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("rst_out_valid", int'(bus8.out_valid), 0);
      checkOutput("rst_out_code", int'(bus8.out_code), 0);
      checkOutput("rst_out_any", int'(bus8.out_any), 0);
      checkOutput("rst_out_err", int'(bus8.out_err), 0);
      checkOutput("rst_err_count", int'(cnt8), 0);
      checkOutput("rst_in_ready", int'(bus8.in_ready), 1);
    end
    rst = 1'b0;
    applyStimulus(8'h10, 2'd0, 4, 1'b1, 1'b0);
    checkOutput("first_beat_latency", int'(bus8.out_valid), 1);

    // Mode selection on one vector, then strict and zero corner cases.
    applyStimulus(8'b0010_1100, 2'd0, 5, 1'b1, 1'b0);
    applyStimulus(8'b0010_1100, 2'd1, 2, 1'b1, 1'b0);
    applyStimulus(8'b0010_1100, 2'd2, 0, 1'b1, 1'b1);
    checkOutput("mode2_err_count", int'(cnt8), 1);
    applyStimulus(8'h40, 2'd2, 6, 1'b1, 1'b0);
    applyStimulus(8'h00, 2'd1, 0, 1'b0, 1'b0);
    applyStimulus(8'h00, 2'd3, 0, 1'b0, 1'b1);
    idleCycles(3);
    checkOutput("directed_drained", q8.size(), 0);

    // Back-pressure: downstream stalls for three cycles mid-stream.
    fork
      begin
        applyStimulus(8'h01, 2'd0, 0, 1'b1, 1'b0);
        applyStimulus(8'h02, 2'd0, 1, 1'b1, 1'b0);
        applyStimulus(8'h04, 2'd0, 2, 1'b1, 1'b0);
        applyStimulus(8'h08, 2'd0, 3, 1'b1, 1'b0);
      end
      begin
        idleCycles(2);
        bus8.out_ready = 1'b0;
        idleCycles(3);
        bus8.out_ready = 1'b1;
      end
    join
    idleCycles(3);
    checkOutput("backpressure_drained", q8.size(), 0);

    // Reset while a beat is held, with another beat offered alongside it.
    bus8.out_ready = 1'b0;
    applyStimulus(8'h01, 2'd0, 0, 1'b1, 1'b0);
    idleCycles(1);
    bus8.out_ready = 1'b1;
    bus8.in_valid  = 1'b1;
    bus8.in_d      = 8'h80;
    rst            = 1'b1;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus8.in_valid = 1'b0;
    q8.delete();
    expCnt8 = 0;
    checkOutput("rst_drops_beat", int'(bus8.out_valid), 0);
    checkOutput("rst_clears_count", int'(cnt8), 0);
    idleCycles(1);
    checkOutput("rst_no_ghost_beat", int'(bus8.out_valid), 0);

    // Two-bit counter saturation and clear priority.
    checkOutput("cnt_start_zero", int'(cntc), 0);
    busc.in_valid = 1'b1;
    busc.in_d     = 8'h00;
    busc.in_mode  = 2'd2;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("cnt_sat_%0d", k), int'(cntc), satSeq[k]);
      checkOutput($sformatf("cnt_out_err_%0d", k), int'(busc.out_err), 1);
    end
    clrc = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("cnt_clr_priority", int'(cntc), 0);
    clrc          = 1'b0;
    busc.in_valid = 1'b0;
    idleCycles(1);
    checkOutput("cnt_after_clr", int'(cntc), 0);

    // N=16 corner vector in both priority modes, then random traffic.
    bus16.out_ready = 1'b1;
    bus16.in_valid  = 1'b1;
    bus16.in_d      = 16'h8001;
    bus16.in_mode   = 2'd0;
    @(negedge clk);
    e.code = 15; e.any = 1'b1; e.err = 1'b0; e.cnt = 0;
    q16.push_back(e);
    @(posedge clk);
    #1;
    bus16.in_mode = 2'd1;
    @(negedge clk);
    e.code = 0;
    q16.push_back(e);
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
    sweep16(300);
    idleCycles(4);
    checkOutput("sweep16_drained", q16.size(), 0);

    sweep2(200);
    idleCycles(4);
    checkOutput("sweep2_drained", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
